// File: rtl/mod12_wrap_monitor.sv
// mod12_wrap_monitor
//
// Watches the output of a modulo-12 up/down counter and, one cycle later,
// reports what kind of transition it just made: hold, step, wrap or jump.
// Keeps a signed (modulo 2^WRAP_W) tally of up-wraps minus down-wraps, a
// sticky flag for out-of-range samples, and a registered two-digit BCD
// 12-hour display of the current count (count 0 is shown as 12).
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-low reset
//   count_in - counter output being monitored, legal range 0..11
//   up_down  - counter direction control (0 = up, 1 = down)
//   clr      - synchronous clear of wrap_cnt and err
//   valid    - high once a previous sample exists
//   wrap_up  - one-cycle pulse on an 11 -> 0 wrap while counting up
//   wrap_dn  - one-cycle pulse on a 0 -> 11 wrap while counting down
//   jump     - one-cycle pulse on any other legal non-hold, non-step move
//   wrap_cnt - up-wraps minus down-wraps, modulo 2^WRAP_W
//   err      - sticky out-of-range flag
//   tens     - BCD tens digit of the displayed hour (4'hF when blank)
//   ones     - BCD ones digit of the displayed hour (4'hF when blank)

module mod12_wrap_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        count_in,
    input  logic              up_down,
    input  logic              clr,
    output logic              valid,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic              jump,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [3:0]        tens,
    output logic [3:0]        ones
);

    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    state_t     state;
    logic [3:0] prev_q;
    logic       dir_q;

    logic       illegal;
    logic       is_hold;
    logic       is_step;
    logic       is_up_wrap;
    logic       is_dn_wrap;
    logic       is_jump;
    logic [3:0] next_tens;
    logic [3:0] next_ones;

    // Transition classification of the pair (prev_q, count_in). dir_q is the
    // direction the counter was told to move when it produced count_in, so
    // it decides which neighbour counts as a step and which end is a wrap.
    // The step conditions guard the ends so that 11->0 and 0->11 never
    // look like steps through 4-bit overflow.
    always_comb begin
        illegal    = (count_in > 4'd11) || (prev_q > 4'd11);
        is_hold    = (count_in == prev_q);
        is_step    = (!dir_q && (prev_q < 4'd11) && (count_in == prev_q + 4'd1)) ||
                     ( dir_q && (prev_q > 4'd0)  && (count_in == prev_q - 4'd1));
        is_up_wrap = !dir_q && (prev_q == 4'd11) && (count_in == 4'd0);
        is_dn_wrap =  dir_q && (prev_q == 4'd0)  && (count_in == 4'd11);
        is_jump    = !illegal && !is_hold && !is_step && !is_up_wrap && !is_dn_wrap;
    end

    // 12-hour display of the current sample; an out-of-range sample blanks
    // both digits.
    always_comb begin
        next_tens = 4'd0;
        next_ones = count_in;
        if (count_in > 4'd11) begin
            next_tens = 4'hF;
            next_ones = 4'hF;
        end else if (count_in == 4'd0) begin
            next_tens = 4'd1;
            next_ones = 4'd2;
        end else if (count_in >= 4'd10) begin
            next_tens = 4'd1;
            next_ones = count_in - 4'd10;
        end
    end

    // Single state register block. IDLE only primes prev_q/dir_q so that the
    // first classified pair is made of two real samples. clr beats a
    // same-cycle wrap on the tally, but an illegal sample beats clr on err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prev_q   <= 4'd0;
            dir_q    <= 1'b0;
            valid    <= 1'b0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
            jump     <= 1'b0;
            wrap_cnt <= '0;
            err      <= 1'b0;
            tens     <= 4'd1;
            ones     <= 4'd2;
        end else begin
            prev_q  <= count_in;
            dir_q   <= up_down;
            valid   <= 1'b1;
            tens    <= next_tens;
            ones    <= next_ones;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            jump    <= 1'b0;
            case (state)
                IDLE: begin
                    state <= TRACK;
                    if (clr) begin
                        wrap_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                TRACK: begin
                    wrap_up <= is_up_wrap;
                    wrap_dn <= is_dn_wrap;
                    jump    <= is_jump;
                    if (clr) begin
                        wrap_cnt <= '0;
                    end else if (is_up_wrap) begin
                        wrap_cnt <= wrap_cnt + WRAP_ONE;
                    end else if (is_dn_wrap) begin
                        wrap_cnt <= wrap_cnt - WRAP_ONE;
                    end
                    if (illegal) begin
                        err <= 1'b1;
                    end else if (clr) begin
                        err <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
